// File: rtl/dmx4_32_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmx4_32_buf_pkg
// Brief    : Shared constants and width helper for the buffered 1-to-4 demux.
// Revision : 1.0
// ============================================================================
package dmx4_32_buf_pkg;

    localparam int CH_N      = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dmx_fifo
// Brief    : Single-clock FIFO for one demux destination; head word is zero when empty.
// Revision : 1.0
// ============================================================================
module dmx_fifo
    import dmx4_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] C_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // Requests are qualified here so the top can pass consumer ready straight through.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_count == C_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/dmx4_32_buf.sv
`default_nettype none
// ============================================================================
// Module   : dmx4_32_buf
// Brief    : Buffered 1-to-4 demultiplexer steering a valid/ready stream into four FIFOs.
// Revision : 1.0
// ============================================================================
module dmx4_32_buf
    import dmx4_32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [WIDTH-1:0]      in_data,
    output logic [CH_N-1:0]       out_valid,
    input  logic [CH_N-1:0]       out_ready,
    output logic [CH_N*WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int PTR_W = clog2(DEPTH);

    logic [CH_N-1:0] w_full;
    logic [CH_N-1:0] w_empty;
    logic [PTR_W:0]  w_count [CH_N];

    // Readiness depends only on stored state, never on out_ready.
    assign in_ready = ~w_full[in_sel];

    for (genvar i = 0; i < CH_N; i++) begin : g_ch
        logic w_push;
        assign w_push = in_valid & in_ready & (in_sel == SEL_W'(i));

        dmx_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push),
            .pop   (out_ready[i]),
            .din   (in_data),
            .dout  (out_data[i*WIDTH +: WIDTH]),
            .full  (w_full[i]),
            .empty (w_empty[i]),
            .count (w_count[i])
        );

        assign out_valid[i] = ~w_empty[i];
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CH_N; i++) begin
            busy = busy | (w_count[i] != '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmx4_32_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmx4_32_buf
// Brief    : Self-checking bench for dmx4_32_buf against per-channel queue model.
// Revision : 1.0
// ============================================================================
module tb_dmx4_32_buf;

    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [31:0]  in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks;
    int errors;

    logic [31:0] mq [4][$];
    logic [31:0] log3 [$];

    dmx4_32_buf #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] s);
        logic [3:0]   ev;
        logic [127:0] ed;
        ev = '0;
        ed = '0;
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0) begin
                ev[i] = 1'b1;
                ed[i*32 +: 32] = mq[i][0];
            end
        end
        chk({tag, ".in_ready"}, {127'd0, in_ready}, {127'd0, (mq[s].size() < DEPTH)});
        chk({tag, ".out_valid"}, {124'd0, out_valid}, {124'd0, ev});
        chk({tag, ".out_data"}, out_data, ed);
        chk({tag, ".busy"}, {127'd0, busy}, {127'd0, (ev != 4'b0)});
    endtask

    // One clock cycle: drive, check against the model, apply the handshake rules to the model.
    task automatic cycle(input string tag, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] r, output logic acc);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        check_outputs(tag, s);
        if (r[3] && out_valid[3]) log3.push_back(out_data[127:96]);
        acc = v && (mq[s].size() < DEPTH);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        end
        if (acc) mq[s].push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mq[i].delete();
    endtask

    initial begin
        logic        acc;
        logic [31:0] k;
        int          budget;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("reset_idle", 1'b0, 2'd0, 32'h0, 4'h0, acc);

        // Steering with all consumers ready.
        for (int i = 0; i < 4; i++) cycle("steer", 1'b1, 2'(i), 32'hA000_0000 + 32'(i), 4'hF, acc);
        repeat (2) cycle("steer_idle", 1'b0, 2'd0, 32'h0, 4'hF, acc);

        // Fill channel 2 and stall the third word, then redirect to channel 1.
        cycle("full", 1'b1, 2'd2, 32'h0000_0201, 4'h0, acc);
        cycle("full", 1'b1, 2'd2, 32'h0000_0202, 4'h0, acc);
        cycle("full_stall", 1'b1, 2'd2, 32'h0000_0203, 4'h0, acc);
        chk("full_third_refused", {127'd0, acc}, 128'd0);
        cycle("full_sel1", 1'b1, 2'd1, 32'h0000_0101, 4'h0, acc);
        chk("full_sel1_accepted", {127'd0, acc}, 128'd1);
        in_valid = 1'b0;
        #1;
        chk("full_ch2_head", {96'd0, out_data[95:64]}, {96'd0, 32'h0000_0201});
        cycle("full_pop", 1'b0, 2'd2, 32'h0, 4'b0100, acc);
        chk("full_ch2_second", {96'd0, out_data[95:64]}, {96'd0, 32'h0000_0202});
        cycle("full_pop", 1'b0, 2'd2, 32'h0, 4'b0100, acc);

        // Channel 1 full; a same-cycle pop must not open the door for the push.
        cycle("nopass_fill", 1'b1, 2'd1, 32'h0000_0102, 4'h0, acc);
        cycle("nopass_refuse", 1'b1, 2'd1, 32'h0000_0103, 4'b0010, acc);
        chk("nopass_refused", {127'd0, acc}, 128'd0);
        cycle("nopass_accept", 1'b1, 2'd1, 32'h0000_0103, 4'h0, acc);
        chk("nopass_accepted", {127'd0, acc}, 128'd1);
        cycle("nopass_full", 1'b1, 2'd1, 32'h0000_0104, 4'h0, acc);
        chk("nopass_count2", {127'd0, acc}, 128'd0);
        repeat (3) cycle("nopass_drain", 1'b0, 2'd1, 32'h0, 4'b0010, acc);

        // Stream ten words through channel 3 with a toggling consumer.
        log3.delete();
        k = 32'd1;
        budget = 0;
        while (k <= 32'd10 && budget < 100) begin
            cycle("wrap", 1'b1, 2'd3, k, {budget[0] == 1'b0, 3'b000}, acc);
            if (acc) k++;
            budget++;
        end
        while (mq[3].size() > 0 && budget < 100) begin
            cycle("wrap_drain", 1'b0, 2'd3, 32'h0, 4'b1000, acc);
            budget++;
        end
        chk("wrap_budget", {127'd0, (budget < 100)}, 128'd1);
        chk("wrap_count", 128'(log3.size()), 128'd10);
        for (int j = 0; j < log3.size(); j++) chk("wrap_order", {96'd0, log3[j]}, 128'(j + 1));

        // Parallel drain.
        for (int i = 0; i < 8; i++) cycle("par_fill", 1'b1, 2'(i % 4), 32'hC000_0000 + 32'(i), 4'h0, acc);
        cycle("par_pop1", 1'b0, 2'd0, 32'h0, 4'hF, acc);
        cycle("par_pop2", 1'b0, 2'd0, 32'h0, 4'hF, acc);
        cycle("par_done", 1'b0, 2'd0, 32'h0, 4'hF, acc);
        chk("par_busy_low", {127'd0, busy}, 128'd0);

        // Asynchronous reset with words buffered and a push pending.
        for (int i = 0; i < 4; i++) cycle("rst_fill", 1'b1, 2'(i), 32'hD000_0000 + 32'(i), 4'h0, acc);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk("rst_out_valid", {124'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle("rst_after", 1'b0, 2'd0, 32'h0, 4'hF, acc);

        // Randomized traffic with one mid-run reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2;
                rst = 1'b1;
                #1;
                clear_model();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            cycle("rand", ($urandom % 4) != 0, 2'($urandom), $urandom, 4'($urandom), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
